bubble_pool: RTL and testbench

BUBBLE_POOL -- requirements
Module: bubble_pool

---
 rtl/bubble_pool_if.sv | 41 ++++
 rtl/bubble_pool.sv | 158 +++++++++++++++
 tb/tb_bubble_pool.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_pool_if.sv
// Bubble pool pixel/control bundle: frame and arrow events in,
// per-slot draw data in, merged pixel plus pop bookkeeping out.
interface bubble_pool_if #(
    parameter int LEVELS = 3,
    parameter int RGB_W  = 8
);
    localparam int N  = (1 << LEVELS) - 1;
    localparam int LW = $clog2(LEVELS) + 1;
    localparam int CW = $clog2(N + 1);

    logic              startOfFrame;
    logic              start;
    logic              arrowHit;
    logic [N-1:0]      drawingRequests;
    logic [N*RGB_W-1:0] RGBouts;
    logic              drawingRequest;
    logic [RGB_W-1:0]  RGBout;
    logic [N-1:0]      alive;
    logic [N-1:0]      spawn;
    logic              arrowConsumed;
    logic [LW-1:0]     popLevel;
    logic              popPulse;
    logic [CW-1:0]     remaining;
    logic              cleared;

    modport master (
        output startOfFrame, start, arrowHit,
        output drawingRequests, RGBouts,
        input  drawingRequest, RGBout, alive, spawn,
        input  arrowConsumed, popLevel, popPulse,
        input  remaining, cleared
    );

    modport slave (
        input  startOfFrame, start, arrowHit,
        input  drawingRequests, RGBouts,
        output drawingRequest, RGBout, alive, spawn,
        output arrowConsumed, popLevel, popPulse,
        output remaining, cleared
    );
endinterface

// File: rtl/bubble_pool.sv
// Binary-tree pool of splitting bubbles: a latched arrow hit pops one
// slot per frame and spawns its two children until the tree is empty.
module bubble_pool #(
    parameter int LEVELS = 3,
    parameter int RGB_W  = 8
) (
    input logic        clk,
    input logic        resetN,
    bubble_pool_if.slave bus
);
    localparam int N  = (1 << LEVELS) - 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(LEVELS) + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

    state_t          state, state_n;
    logic [N-1:0]    alive_q, alive_n;
    logic [N-1:0]    spawn_q, spawn_n;
    logic            pend_q, pend_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic            cons_q, cons_n;
    logic [LW-1:0]   lvl_q, lvl_n;
    logic            pop_q, pop_n;
    logic            clr_q, clr_n;
    logic [CW-1:0]   rem_q;

    logic [N-1:0]    vis;
    logic [N-1:0]    hitv;
    logic [IW-1:0]   hit_idx;
    logic [N-1:0]    sel;
    logic [N-1:0]    kids;
    logic [LW-1:0]   pend_lvl;
    logic [RGB_W-1:0] rgb;

    function automatic logic [LW-1:0] level_of(input logic [IW-1:0] i);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 1; k < LEVELS; k++)
            if (int'(i) + 1 >= (1 << k)) l = LW'(k);
        return l;
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) c = c + CW'(v[k]);
        return c;
    endfunction

    assign vis  = bus.drawingRequests & alive_q;
    assign hitv = bus.arrowHit ? vis : '0;

    // Downward scan so the lowest visible index wins
    always_comb begin
        hit_idx = '0;
        rgb     = '1;
        for (int i = N - 1; i >= 0; i--) begin
            if (hitv[i]) hit_idx = IW'(i);
            if (vis[i])  rgb = bus.RGBouts[i*RGB_W +: RGB_W];
        end
    end

    assign pend_lvl = level_of(idx_q);

    always_comb begin
        sel  = '0;
        kids = '0;
        for (int j = 0; j < N; j++) begin
            sel[j] = (j == int'(idx_q));
            if (pend_lvl < LW'(LEVELS - 1))
                kids[j] = (j == 2*int'(idx_q) + 1) ||
                          (j == 2*int'(idx_q) + 2);
        end
    end

    always_comb begin
        state_n = state;
        alive_n = alive_q;
        pend_n  = pend_q;
        idx_n   = idx_q;
        spawn_n = '0;
        cons_n  = 1'b0;
        lvl_n   = lvl_q;
        pop_n   = 1'b0;
        clr_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    alive_n = N'(1);
                    spawn_n = N'(1);
                    state_n = RUN;
                end
            end
            RUN: begin
                // A pending hit blocks new latches, including the SOF cycle
                if (bus.startOfFrame && pend_q) begin
                    state_n = COMMIT;
                end else if (!pend_q && |hitv) begin
                    pend_n = 1'b1;
                    idx_n  = hit_idx;
                    cons_n = 1'b1;
                end
            end
            COMMIT: begin
                alive_n = (alive_q & ~sel) | kids;
                spawn_n = kids;
                lvl_n   = pend_lvl;
                pop_n   = 1'b1;
                pend_n  = 1'b0;
                if (alive_n == '0) begin
                    clr_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            alive_q <= '0;
            spawn_q <= '0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            cons_q  <= 1'b0;
            lvl_q   <= '0;
            pop_q   <= 1'b0;
            clr_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state   <= state_n;
            alive_q <= alive_n;
            spawn_q <= spawn_n;
            pend_q  <= pend_n;
            idx_q   <= idx_n;
            cons_q  <= cons_n;
            lvl_q   <= lvl_n;
            pop_q   <= pop_n;
            clr_q   <= clr_n;
            rem_q   <= popcnt(alive_q);
        end
    end

    assign bus.drawingRequest = |vis;
    assign bus.RGBout         = rgb;
    assign bus.alive          = alive_q;
    assign bus.spawn          = spawn_q;
    assign bus.arrowConsumed  = cons_q;
    assign bus.popLevel       = lvl_q;
    assign bus.popPulse       = pop_q;
    assign bus.remaining      = rem_q;
    assign bus.cleared        = clr_q;
endmodule

// File: tb/tb_bubble_pool.sv
// Directed bench for bubble_pool with LEVELS=3 (seven slots):
// start, splits, pixel merge, hit arbitration, clearing and reset.
module tb_bubble_pool;
    localparam int LEVELS = 3;
    localparam int RGB_W  = 8;
    localparam int N      = 7;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    bubble_pool_if #(.LEVELS(LEVELS), .RGB_W(RGB_W)) bus ();

    bubble_pool #(.LEVELS(LEVELS), .RGB_W(RGB_W)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int n_cons  = 0;
    int n_pop   = 0;
    int n_clr   = 0;

    always @(negedge clk) begin
        if (bus.arrowConsumed) n_cons++;
        if (bus.popPulse) n_pop++;
        if (bus.cleared) n_clr++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input int idx);
        bus.arrowHit = 1'b1;
        bus.drawingRequests = N'(1) << idx;
        tick();
        bus.arrowHit = 1'b0;
        bus.drawingRequests = '0;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        bus.drawingRequests = 7'b1111111;
        #12;
        vectors++; if (bus.alive !== 7'b0) begin errors++; $display("FAIL rst_alive got %b want %b", bus.alive, 7'b0); end
        vectors++; if (bus.spawn !== 7'b0) begin errors++; $display("FAIL rst_spawn got %b want %b", bus.spawn, 7'b0); end
        vectors++; if (bus.remaining !== 3'd0) begin errors++; $display("FAIL rst_remaining got %0d want 0", bus.remaining); end
        vectors++; if (bus.popLevel !== 3'd0) begin errors++; $display("FAIL rst_poplevel got %0d want 0", bus.popLevel); end
        vectors++; if (bus.drawingRequest !== 1'b0) begin errors++; $display("FAIL rst_drawreq got %b want 0", bus.drawingRequest); end
        vectors++; if (bus.RGBout !== 8'hFF) begin errors++; $display("FAIL rst_rgb got %h want ff", bus.RGBout); end
        bus.drawingRequests = '0;
        @(negedge clk);
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.spawn !== 7'b0000001) begin errors++; $display("FAIL start_spawn got %b want %b", bus.spawn, 7'b0000001); end
        vectors++; if (bus.alive !== 7'b0000001) begin errors++; $display("FAIL start_alive got %b want %b", bus.alive, 7'b0000001); end
        tick();
        vectors++; if (bus.spawn !== 7'b0) begin errors++; $display("FAIL start_spawn_end got %b want %b", bus.spawn, 7'b0); end
        vectors++; if (bus.remaining !== 3'd1) begin errors++; $display("FAIL start_remaining got %0d want 1", bus.remaining); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.spawn !== 7'b0) begin errors++; $display("FAIL start_ignored got %b want %b", bus.spawn, 7'b0); end
    endtask

    task automatic test_pop_root;
        int c0;
        c0 = n_cons;
        bus.arrowHit = 1'b1;
        bus.drawingRequests = 7'b0000001;
        tick();
        bus.arrowHit = 1'b0;
        bus.drawingRequests = '0;
        vectors++; if (bus.arrowConsumed !== 1'b1) begin errors++; $display("FAIL root_consumed got %b want 1", bus.arrowConsumed); end
        vectors++; if (bus.alive !== 7'b0000001) begin errors++; $display("FAIL root_prepop got %b want %b", bus.alive, 7'b0000001); end
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
        vectors++; if (bus.alive !== 7'b0000110) begin errors++; $display("FAIL root_alive got %b want %b", bus.alive, 7'b0000110); end
        vectors++; if (bus.spawn !== 7'b0000110) begin errors++; $display("FAIL root_spawn got %b want %b", bus.spawn, 7'b0000110); end
        vectors++; if (bus.popLevel !== 3'd0) begin errors++; $display("FAIL root_poplevel got %0d want 0", bus.popLevel); end
        vectors++; if (bus.popPulse !== 1'b1) begin errors++; $display("FAIL root_poppulse got %b want 1", bus.popPulse); end
        tick();
        vectors++; if (bus.remaining !== 3'd2) begin errors++; $display("FAIL root_remaining got %0d want 2", bus.remaining); end
        vectors++; if (bus.spawn !== 7'b0) begin errors++; $display("FAIL root_spawn_end got %b want %b", bus.spawn, 7'b0); end
        vectors++; if (n_cons - c0 !== 1) begin errors++; $display("FAIL root_consume_cnt got %0d want 1", n_cons - c0); end
    endtask

    task automatic test_rgb;
        bus.drawingRequests = 7'b0000111;
        #1;
        vectors++; if (bus.RGBout !== 8'h1C) begin errors++; $display("FAIL rgb_slot1 got %h want 1c", bus.RGBout); end
        vectors++; if (bus.drawingRequest !== 1'b1) begin errors++; $display("FAIL rgb_req1 got %b want 1", bus.drawingRequest); end
        bus.drawingRequests = 7'b0000100;
        #1;
        vectors++; if (bus.RGBout !== 8'hE0) begin errors++; $display("FAIL rgb_slot2 got %h want e0", bus.RGBout); end
        bus.drawingRequests = 7'b1000001;
        #1;
        vectors++; if (bus.drawingRequest !== 1'b0) begin errors++; $display("FAIL rgb_dead_req got %b want 0", bus.drawingRequest); end
        vectors++; if (bus.RGBout !== 8'hFF) begin errors++; $display("FAIL rgb_dead got %h want ff", bus.RGBout); end
        bus.drawingRequests = '0;
        tick();
    endtask

    task automatic test_two_hits;
        int c0;
        int p0;
        c0 = n_cons;
        p0 = n_pop;
        bus.arrowHit = 1'b1;
        bus.drawingRequests = 7'b0000010;
        tick();
        bus.drawingRequests = 7'b0000100;
        tick();
        bus.arrowHit = 1'b0;
        bus.drawingRequests = '0;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
        vectors++; if (bus.alive !== 7'b0011100) begin errors++; $display("FAIL two_alive1 got %b want %b", bus.alive, 7'b0011100); end
        vectors++; if (bus.spawn !== 7'b0011000) begin errors++; $display("FAIL two_spawn1 got %b want %b", bus.spawn, 7'b0011000); end
        vectors++; if (bus.popLevel !== 3'd1) begin errors++; $display("FAIL two_poplevel1 got %0d want 1", bus.popLevel); end
        bus.arrowHit = 1'b1;
        bus.drawingRequests = 7'b0000100;
        tick();
        bus.drawingRequests = '0;
        bus.arrowHit = 1'b0;
        // a hit on slot 3 in the committing SOF cycle must be dropped
        bus.startOfFrame = 1'b1;
        bus.arrowHit = 1'b1;
        bus.drawingRequests = 7'b0001000;
        tick();
        bus.startOfFrame = 1'b0;
        bus.arrowHit = 1'b0;
        bus.drawingRequests = '0;
        tick();
        vectors++; if (bus.alive !== 7'b1111000) begin errors++; $display("FAIL two_alive2 got %b want %b", bus.alive, 7'b1111000); end
        vectors++; if (bus.spawn !== 7'b1100000) begin errors++; $display("FAIL two_spawn2 got %b want %b", bus.spawn, 7'b1100000); end
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
        tick();
        vectors++; if (n_cons - c0 !== 2) begin errors++; $display("FAIL two_consume_cnt got %0d want 2", n_cons - c0); end
        vectors++; if (n_pop - p0 !== 2) begin errors++; $display("FAIL two_pop_cnt got %0d want 2", n_pop - p0); end
        vectors++; if (bus.alive !== 7'b1111000) begin errors++; $display("FAIL two_idle_sof got %b want %b", bus.alive, 7'b1111000); end
        vectors++; if (bus.remaining !== 3'd4) begin errors++; $display("FAIL two_remaining got %0d want 4", bus.remaining); end
    endtask

    task automatic test_clear;
        int k0;
        k0 = n_clr;
        pop(3);
        vectors++; if (bus.popLevel !== 3'd2) begin errors++; $display("FAIL leaf_poplevel got %0d want 2", bus.popLevel); end
        vectors++; if (bus.spawn !== 7'b0) begin errors++; $display("FAIL leaf_spawn got %b want %b", bus.spawn, 7'b0); end
        vectors++; if (bus.alive !== 7'b1110000) begin errors++; $display("FAIL leaf_alive got %b want %b", bus.alive, 7'b1110000); end
        tick();
        vectors++; if (bus.remaining !== 3'd3) begin errors++; $display("FAIL leaf_remaining got %0d want 3", bus.remaining); end
        pop(4);
        pop(5);
        vectors++; if (n_clr - k0 !== 0) begin errors++; $display("FAIL early_cleared got %0d want 0", n_clr - k0); end
        pop(6);
        vectors++; if (bus.alive !== 7'b0) begin errors++; $display("FAIL clear_alive got %b want %b", bus.alive, 7'b0); end
        vectors++; if (bus.popLevel !== 3'd2) begin errors++; $display("FAIL clear_poplevel got %0d want 2", bus.popLevel); end
        tick();
        tick();
        vectors++; if (bus.remaining !== 3'd0) begin errors++; $display("FAIL clear_remaining got %0d want 0", bus.remaining); end
        vectors++; if (n_clr - k0 !== 1) begin errors++; $display("FAIL clear_cnt got %0d want 1", n_clr - k0); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.spawn !== 7'b0000001) begin errors++; $display("FAIL restart_spawn got %b want %b", bus.spawn, 7'b0000001); end
        tick();
    endtask

    task automatic test_reset_mid;
        int p0;
        bus.arrowHit = 1'b1;
        bus.drawingRequests = 7'b0000001;
        tick();
        bus.arrowHit = 1'b0;
        bus.drawingRequests = '0;
        #1;
        resetN = 1'b0;
        #1;
        vectors++; if (bus.alive !== 7'b0) begin errors++; $display("FAIL mid_alive got %b want %b", bus.alive, 7'b0); end
        vectors++; if (bus.arrowConsumed !== 1'b0) begin errors++; $display("FAIL mid_consumed got %b want 0", bus.arrowConsumed); end
        vectors++; if (bus.remaining !== 3'd0) begin errors++; $display("FAIL mid_remaining got %0d want 0", bus.remaining); end
        vectors++; if (bus.popLevel !== 3'd0) begin errors++; $display("FAIL mid_poplevel got %0d want 0", bus.popLevel); end
        @(negedge clk);
        resetN = 1'b1;
        tick();
        p0 = n_pop;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
        tick();
        vectors++; if (n_pop - p0 !== 0) begin errors++; $display("FAIL mid_nopop got %0d want 0", n_pop - p0); end
        vectors++; if (bus.alive !== 7'b0) begin errors++; $display("FAIL mid_idle got %b want %b", bus.alive, 7'b0); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.alive !== 7'b0000001) begin errors++; $display("FAIL mid_restart got %b want %b", bus.alive, 7'b0000001); end
        vectors++; if (bus.spawn !== 7'b0000001) begin errors++; $display("FAIL mid_respawn got %b want %b", bus.spawn, 7'b0000001); end
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.start = 1'b0;
        bus.arrowHit = 1'b0;
        bus.drawingRequests = '0;
        bus.RGBouts = {8'h66, 8'h44, 8'h33, 8'h22, 8'hE0, 8'h1C, 8'h55};
        test_reset();
        test_start();
        test_pop_root();
        test_rgb();
        test_two_hits();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
